// File: rtl/reg_wb_arb.sv
// Write-back arbiter for the register file's single write port.
// ALU results take priority, load returns wait in a FIFO, and forced slots bound their wait.
module reg_wb_arb #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int REG_FILE_SIZE = 16,
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alu_w_valid,
  output logic                             alu_w_ready,
  input  logic [ADDR_WIDTH-1:0]            alu_w_addr,
  input  logic [DATA_WIDTH-1:0]            alu_w_data,
  input  logic                             ld_issue_valid,
  input  logic [ADDR_WIDTH-1:0]            ld_issue_addr,
  input  logic                             ld_ret_valid,
  output logic                             ld_ret_ready,
  input  logic [ADDR_WIDTH-1:0]            ld_ret_addr,
  input  logic [DATA_WIDTH-1:0]            ld_ret_data,
  output logic                             reg_w_en,
  output logic [ADDR_WIDTH-1:0]            reg_w_addr,
  output logic [DATA_WIDTH-1:0]            reg_w_data,
  output logic [REG_FILE_SIZE-1:0]         pending,
  output logic [$clog2(LD_FIFO_DEPTH):0]   ld_fifo_count,
  output logic                             hazard_err
);

  localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(LD_FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } ld_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LOAD
  } grant_e;

  ld_entry_t                mem_q [LD_FIFO_DEPTH];
  ld_entry_t                mem_d [LD_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [SC_W-1:0]          starve_q, starve_d;
  logic [REG_FILE_SIZE-1:0] pending_q, pending_d;
  logic                     hazard_q, hazard_d;
  logic                     reg_w_en_q, reg_w_en_d;
  logic                     reg_w_ld_q, reg_w_ld_d;
  logic [ADDR_WIDTH-1:0]    reg_w_addr_q, reg_w_addr_d;
  logic [DATA_WIDTH-1:0]    reg_w_data_q, reg_w_data_d;

  logic      fifo_empty;
  logic      force_ld;
  logic      push;
  logic      pop;
  grant_e    grant;
  ld_entry_t head;

  always_comb begin
    fifo_empty   = (count_q == '0);
    force_ld     = (starve_q == STARVE_MAX) && !fifo_empty;
    alu_w_ready  = !rst && !force_ld;
    ld_ret_ready = !rst && (count_q < FIFO_FULL);
    push         = ld_ret_valid && ld_ret_ready;
    head         = mem_q[rd_ptr_q];

    grant = GNT_NONE;
    if (rst) begin
      grant = GNT_NONE;
    end else if (force_ld) begin
      grant = GNT_LOAD;
    end else if (alu_w_valid) begin
      grant = GNT_ALU;
    end else if (!fifo_empty) begin
      grant = GNT_LOAD;
    end
    pop = (grant == GNT_LOAD);
  end

  // A push into an empty FIFO is never popped in the same cycle: pop only reads stored entries.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: ld_ret_addr, data: ld_ret_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (grant == GNT_ALU && starve_q != STARVE_MAX) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_comb begin
    reg_w_en_d   = 1'b0;
    reg_w_ld_d   = 1'b0;
    reg_w_addr_d = reg_w_addr_q;
    reg_w_data_d = reg_w_data_q;
    case (grant)
      GNT_ALU: begin
        reg_w_en_d   = 1'b1;
        reg_w_addr_d = alu_w_addr;
        reg_w_data_d = alu_w_data;
      end
      GNT_LOAD: begin
        reg_w_en_d   = 1'b1;
        reg_w_ld_d   = 1'b1;
        reg_w_addr_d = head.addr;
        reg_w_data_d = head.data;
      end
      default: begin
        reg_w_en_d = 1'b0;
      end
    endcase
  end

  // Clear follows the presented load write so the bit drops when the value becomes readable.
  always_comb begin
    pending_d = pending_q;
    hazard_d  = hazard_q;
    if (reg_w_en_q && reg_w_ld_q) begin
      pending_d[reg_w_addr_q] = 1'b0;
    end
    if (ld_issue_valid) begin
      pending_d[ld_issue_addr] = 1'b1;
    end
    if (grant == GNT_ALU && pending_q[alu_w_addr]) begin
      hazard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      pending_q    <= '0;
      hazard_q     <= 1'b0;
      reg_w_en_q   <= 1'b0;
      reg_w_ld_q   <= 1'b0;
      reg_w_addr_q <= '0;
      reg_w_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      pending_q    <= pending_d;
      hazard_q     <= hazard_d;
      reg_w_en_q   <= reg_w_en_d;
      reg_w_ld_q   <= reg_w_ld_d;
      reg_w_addr_q <= reg_w_addr_d;
      reg_w_data_q <= reg_w_data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign reg_w_en      = reg_w_en_q;
  assign reg_w_addr    = reg_w_addr_q;
  assign reg_w_data    = reg_w_data_q;
  assign pending       = pending_q;
  assign ld_fifo_count = count_q;
  assign hazard_err    = hazard_q;

endmodule
